// File: rtl/mem_seq.sv
// Memory-cycle sequencer in front of the 4Kx12 main RAM. It runs READ, WRITE,
// auto-index INDIRECT and ISZ cycles, with the increment done in hardware.
module mem_seq #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          skip,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_dataI,
    input  logic [DW-1:0] ram_dataO,
    output logic [2:0]    dbg_state
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_IND   = 2'b10;
    localparam logic [1:0] OP_ISZ   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_rdata;
    logic          r_skip;

    logic          w_auto;
    logic          w_rmw;
    logic [DW-1:0] w_inc;

    // Auto-index locations are 0o0010..0o0017: everything above bit 2 equals 1.
    assign w_auto = (r_addr[AW-1:3] == (AW-3)'(1));
    assign w_rmw  = (r_op == OP_ISZ) || ((r_op == OP_IND) && w_auto);
    assign w_inc  = ram_dataO + {{(DW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_rdata <= '0;
            r_skip  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_state <= (op == OP_WRITE) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (w_rmw) begin
                        r_data  <= w_inc;
                        r_state <= S_WB;
                    end else begin
                        r_data  <= ram_dataO;
                        r_rdata <= ram_dataO;
                        r_skip  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_WB: begin
                    // Result is published as the DONE state is entered so it
                    // holds steady until the next completion.
                    r_rdata <= r_data;
                    r_skip  <= (r_op == OP_ISZ) && (r_data == '0);
                    r_state <= S_DONE;
                end
                S_WR: begin
                    r_data  <= r_wdata;
                    r_rdata <= r_wdata;
                    r_skip  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode from the state register so async reset drops them at once.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign ram_oe    = (r_state == S_RD);
    assign ram_we    = (r_state == S_WR) || (r_state == S_WB);
    assign ram_addr  = r_addr;
    assign ram_dataI = (r_state == S_WB) ? r_data : r_wdata;
    assign rdata     = r_rdata;
    assign skip      = r_skip;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq with a behavioural 4Kx12 RAM acting on the falling edge.
module tb_mem_seq;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_IND   = 2'b10;
    localparam logic [1:0] OP_ISZ   = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [11:0] wdata;
    logic        busy;
    logic        done;
    logic [11:0] rdata;
    logic        skip;
    logic        ram_oe;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [11:0] ram_dataI;
    logic [11:0] ram_dataO;
    logic [2:0]  dbg_state;

    logic [11:0] mem [0:4095];
    logic [11:0] r_q = '0;
    logic        bk_en = 1'b0;
    logic [11:0] bk_addr = '0;
    logic [11:0] bk_data = '0;

    int checks   = 0;
    int failures = 0;
    int overlap_cnt = 0;
    int we_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mem_seq #(.AW(12), .DW(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .skip(skip),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dataI(ram_dataI),
        .ram_dataO(ram_dataO), .dbg_state(dbg_state)
    );

    // RAM model: acts on the falling edge; backdoor port used only while idle.
    always @(negedge clk) begin
        if (bk_en) mem[bk_addr] <= bk_data;
        else if (rst_n && ram_we) mem[ram_addr] <= ram_dataI;
        if (ram_oe) r_q <= mem[ram_addr];
    end
    assign ram_dataO = ram_oe ? r_q : 12'o0000;

    always @(negedge clk) begin
        if (ram_oe && ram_we) overlap_cnt++;
        if (ram_we) we_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        bk_en = 1'b1; bk_addr = a; bk_data = d;
        @(negedge clk); #1;
        bk_en = 1'b0;
    endtask

    // Issues one request, scrambles the inputs after acceptance, and returns
    // the number of cycles from acceptance to the done pulse (99 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [11:0] a, input logic [11:0] w,
                          output int lat);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = w;
        @(posedge clk); #1;
        req = 1'b0; op = ~o; addr = ~a; wdata = ~w;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // With req held high: cycles from one done pulse to the next, with
    // garbage inputs applied right after the new request is taken.
    task automatic wait_gap(output int g);
        @(posedge clk);
        @(posedge clk); #1;
        op = OP_WRITE; addr = 12'o0000; wdata = 12'o7777;
        g = 99;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                g = i;
                break;
            end
        end
    endtask

    int lat;
    int we_before;
    int done_before;

    initial begin
        rst_n = 1'b0; req = 1'b0; op = OP_READ; addr = '0; wdata = '0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_oe", ram_oe, 0);
        check("rst_we", ram_we, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_dataI", ram_dataI, 0);
        check("rst_rdata", rdata, 0);
        check("rst_skip", skip, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        poke(12'o0000, 12'o0001);
        poke(12'o0200, 12'o1234);
        poke(12'o0010, 12'o0377);
        poke(12'o0007, 12'o0123);
        poke(12'o0020, 12'o0456);
        poke(12'o0017, 12'o7777);
        poke(12'o3000, 12'o7777);
        poke(12'o3001, 12'o0005);
        poke(12'o0011, 12'o0042);

        // Plain read
        we_before = we_cnt;
        run_op(OP_READ, 12'o0200, 12'o0000, lat);
        check("read_lat", lat, 2);
        check("read_rdata", rdata, 12'o1234);
        check("read_skip", skip, 0);
        check("read_no_we", we_cnt - we_before, 0);
        @(negedge clk);
        check("read_busy_after", busy, 0);
        check("read_done_after", done, 0);
        check("read_rdata_hold", rdata, 12'o1234);

        // Write then read back
        run_op(OP_WRITE, 12'o4000, 12'o5555, lat);
        check("write_lat", lat, 2);
        check("write_rdata", rdata, 12'o5555);
        check("write_mem", mem[12'o4000], 12'o5555);
        run_op(OP_READ, 12'o4000, 12'o0000, lat);
        check("readback_rdata", rdata, 12'o5555);

        // Indirect: auto-index and its boundaries
        run_op(OP_IND, 12'o0010, 12'o0000, lat);
        check("ind10_lat", lat, 3);
        check("ind10_rdata", rdata, 12'o0400);
        check("ind10_mem", mem[12'o0010], 12'o0400);
        check("ind10_skip", skip, 0);
        we_before = we_cnt;
        run_op(OP_IND, 12'o0007, 12'o0000, lat);
        check("ind07_lat", lat, 2);
        check("ind07_rdata", rdata, 12'o0123);
        run_op(OP_IND, 12'o0020, 12'o0000, lat);
        check("ind20_lat", lat, 2);
        check("ind20_rdata", rdata, 12'o0456);
        check("ind_no_we", we_cnt - we_before, 0);
        check("ind20_mem", mem[12'o0020], 12'o0456);
        run_op(OP_IND, 12'o0017, 12'o0000, lat);
        check("ind17_lat", lat, 3);
        check("ind17_rdata", rdata, 12'o0000);
        check("ind17_skip", skip, 0);
        check("ind17_mem", mem[12'o0017], 12'o0000);

        // ISZ with wrap, then a plain increment
        run_op(OP_ISZ, 12'o3000, 12'o0000, lat);
        check("isz_wrap_lat", lat, 3);
        check("isz_wrap_rdata", rdata, 12'o0000);
        check("isz_wrap_skip", skip, 1);
        check("isz_wrap_mem", mem[12'o3000], 12'o0000);
        run_op(OP_ISZ, 12'o3001, 12'o0000, lat);
        check("isz_rdata", rdata, 12'o0006);
        check("isz_skip", skip, 0);

        // Back-to-back with req held high: READ, ISZ, WRITE
        @(negedge clk);
        req = 1'b1; op = OP_READ; addr = 12'o0200; wdata = 12'o0000;
        @(posedge clk); #1;
        op = OP_WRITE; addr = 12'o0000; wdata = 12'o7777;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("b2b_read_lat", lat, 2);
        check("b2b_read_rdata", rdata, 12'o1234);
        op = OP_ISZ; addr = 12'o3001; wdata = 12'o0000;
        wait_gap(lat);
        check("b2b_isz_gap", lat, 4);
        check("b2b_isz_rdata", rdata, 12'o0007);
        check("b2b_isz_skip", skip, 0);
        op = OP_WRITE; addr = 12'o4000; wdata = 12'o7070;
        wait_gap(lat);
        req = 1'b0;
        check("b2b_write_gap", lat, 3);
        check("b2b_write_rdata", rdata, 12'o7070);
        check("b2b_mem4000", mem[12'o4000], 12'o7070);
        check("b2b_mem3001", mem[12'o3001], 12'o0007);
        check("b2b_mem0", mem[12'o0000], 12'o0001);

        // Reset during the write-back of an ISZ
        @(negedge clk);
        req = 1'b1; op = OP_ISZ; addr = 12'o0011; wdata = 12'o0000;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("wb_we_before_rst", ram_we, 1);
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check("wbrst_we", ram_we, 0);
        check("wbrst_oe", ram_oe, 0);
        check("wbrst_busy", busy, 0);
        check("wbrst_done", done, 0);
        check("wbrst_addr", ram_addr, 0);
        check("wbrst_dataI", ram_dataI, 0);
        check("wbrst_rdata", rdata, 0);
        check("wbrst_skip", skip, 0);
        repeat (3) @(negedge clk);
        #1;
        check("wbrst_mem", mem[12'o0011], 12'o0042);
        check("wbrst_no_done", done_cnt - done_before, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);

        check("oe_we_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
